// File: rtl/uart_program_loader.sv
// uart_program_loader
// Boot-time program loader. Receives a UART 8N1 byte stream, assembles
// little-endian 32-bit words and writes them to consecutive instruction
// memory addresses. The core is held in reset until the whole image is in.
// Stream format: a 4-byte little-endian word count, then that many words.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   rx_serial    asynchronous UART line, idle high
//   imem_we      one-cycle instruction memory write strobe
//   imem_addr    word address of the write
//   imem_wdata   assembled instruction word
//   cpu_rst      pipeline reset, high until the image is loaded
//   load_done    high once the image is fully written
//   frame_err    sticky, a stop bit was sampled low
//   overflow_err sticky, image longer than memory depth
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_serial,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst,
    output logic                  load_done,
    output logic                  frame_err,
    output logic                  overflow_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0]      DEPTH     = 32'(2 ** ADDR_WIDTH);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_IDLE} rx_state_t;
    typedef enum logic [1:0] {L_LEN, L_DATA, L_DONE} ld_state_t;

    logic                  rx_meta_q, rx_sync_q;
    rx_state_t             rx_state_q, rx_state_d;
    logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  byte_valid_q, byte_valid_d;
    logic                  frame_err_q, frame_err_d;

    ld_state_t             ld_state_q, ld_state_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [31:0]           word_buf_q, word_buf_d;
    logic [31:0]           word_count_q, word_count_d;
    logic [31:0]           word_idx_q, word_idx_d;
    logic                  word_done_q, word_done_d;
    logic                  imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_wdata_q, imem_wdata_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  load_done_q, load_done_d;
    logic                  overflow_err_q, overflow_err_d;
    logic [31:0]           assembled_s;

    // The completed word: current byte lands in the top lane.
    assign assembled_s = {shift_q, word_buf_q[23:0]};

    // UART receiver next-state: bit timing, sampling and frame check.
    always_comb begin
        rx_state_d   = rx_state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = frame_err_q;
        case (rx_state_q)
            RX_IDLE: begin
                clk_cnt_d = '0;
                if (!rx_sync_q) begin
                    rx_state_d = RX_START;
                    bit_cnt_d  = 3'd0;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    // A start bit that is gone by mid-bit was a glitch.
                    if (!rx_sync_q) begin
                        rx_state_d = RX_DATA;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_state_d = RX_DATA;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    if (rx_sync_q) begin
                        byte_valid_d = 1'b1;
                        rx_state_d   = RX_IDLE;
                    end else begin
                        frame_err_d  = 1'b1;
                        rx_state_d   = RX_WAIT_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_WAIT_IDLE: begin
                if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_WAIT_IDLE;
                end
            end
            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // Loader next-state: length header, word assembly, memory writes.
    always_comb begin
        ld_state_d     = ld_state_q;
        byte_idx_d     = byte_idx_q;
        word_buf_d     = word_buf_q;
        word_count_d   = word_count_q;
        word_idx_d     = word_idx_q;
        word_done_d    = 1'b0;
        imem_we_d      = 1'b0;
        imem_addr_d    = imem_addr_q;
        imem_wdata_d   = imem_wdata_q;
        cpu_rst_d      = cpu_rst_q;
        load_done_d    = load_done_q;
        overflow_err_d = overflow_err_q;
        case (ld_state_q)
            L_LEN: begin
                if (byte_valid_q) begin
                    word_buf_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        word_count_d = assembled_s;
                        word_idx_d   = 32'd0;
                        if (assembled_s == 32'd0) begin
                            ld_state_d  = L_DONE;
                            load_done_d = 1'b1;
                            cpu_rst_d   = 1'b0;
                        end else begin
                            ld_state_d  = L_DATA;
                        end
                    end else begin
                        ld_state_d = L_LEN;
                    end
                end else begin
                    ld_state_d = L_LEN;
                end
            end
            L_DATA: begin
                // word_done_q marks the write cycle, when word_idx_q has already advanced.
                if (word_done_q && (word_idx_q == word_count_q)) begin
                    ld_state_d  = L_DONE;
                    load_done_d = 1'b1;
                    cpu_rst_d   = 1'b0;
                end else if (byte_valid_q) begin
                    word_buf_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        word_done_d = 1'b1;
                        word_idx_d  = word_idx_q + 32'd1;
                        // Words past the memory end are consumed but never written.
                        if (word_idx_q < DEPTH) begin
                            imem_we_d    = 1'b1;
                            imem_addr_d  = word_idx_q[ADDR_WIDTH-1:0];
                            imem_wdata_d = assembled_s;
                        end else begin
                            overflow_err_d = 1'b1;
                        end
                    end else begin
                        word_done_d = 1'b0;
                    end
                end else begin
                    ld_state_d = L_DATA;
                end
            end
            L_DONE: begin
                ld_state_d = L_DONE;
            end
            default: begin
                ld_state_d = L_LEN;
            end
        endcase
    end

    // State registers, synchronizer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q      <= 1'b1;
            rx_sync_q      <= 1'b1;
            rx_state_q     <= RX_IDLE;
            clk_cnt_q      <= '0;
            bit_cnt_q      <= 3'd0;
            shift_q        <= 8'd0;
            byte_valid_q   <= 1'b0;
            frame_err_q    <= 1'b0;
            ld_state_q     <= L_LEN;
            byte_idx_q     <= 2'd0;
            word_buf_q     <= 32'd0;
            word_count_q   <= 32'd0;
            word_idx_q     <= 32'd0;
            word_done_q    <= 1'b0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= '0;
            imem_wdata_q   <= 32'd0;
            cpu_rst_q      <= 1'b1;
            load_done_q    <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            rx_meta_q      <= rx_serial;
            rx_sync_q      <= rx_meta_q;
            rx_state_q     <= rx_state_d;
            clk_cnt_q      <= clk_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            byte_valid_q   <= byte_valid_d;
            frame_err_q    <= frame_err_d;
            ld_state_q     <= ld_state_d;
            byte_idx_q     <= byte_idx_d;
            word_buf_q     <= word_buf_d;
            word_count_q   <= word_count_d;
            word_idx_q     <= word_idx_d;
            word_done_q    <= word_done_d;
            imem_we_q      <= imem_we_d;
            imem_addr_q    <= imem_addr_d;
            imem_wdata_q   <= imem_wdata_d;
            cpu_rst_q      <= cpu_rst_d;
            load_done_q    <= load_done_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_rst      = cpu_rst_q;
    assign load_done    = load_done_q;
    assign frame_err    = frame_err_q;
    assign overflow_err = overflow_err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Testbench for uart_program_loader with CLKS_PER_BIT=16, ADDR_WIDTH=4.
// Word-level expectations come from a vector table; reset, glitch, framing
// and zero-length cases are hand-written sequences.
module tb_uart_program_loader;

    localparam int CPB = 16;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_serial = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst, load_done, frame_err, overflow_err;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .rx_serial(rx_serial),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .load_done(load_done),
        .frame_err(frame_err), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]    b0, b1, b2, b3;   // bytes in transmit order
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [31:0]   exp_data;
        logic          exp_ovf;          // overflow_err after this word
    } vec_t;

    vec_t vecs [19];

    int total = 0;
    int bad   = 0;

    // Write monitor, sampled on the falling edge.
    logic [AW-1:0] wq_addr [$];
    logic [31:0]   wq_data [$];
    int cyc = 0, last_we_cyc = -100, done_cyc = -200, wide_cnt = 0;
    logic prev_we = 1'b0, prev_done = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (imem_we) begin
            wq_addr.push_back(imem_addr);
            wq_data.push_back(imem_wdata);
            last_we_cyc = cyc;
            if (prev_we) wide_cnt = wide_cnt + 1;
        end
        if (load_done && !prev_done) done_cyc = cyc;
        prev_we   = imem_we;
        prev_done = load_done;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_serial = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            tick(CPB);
        end
        rx_serial = stop_bit;
        tick(CPB);
        rx_serial = 1'b1;
        tick(4);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[31:24], 1'b1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_we"},   {31'd0, imem_we},      32'd0);
        chk({tag, "_addr"}, {28'd0, imem_addr},    32'd0);
        chk({tag, "_data"}, imem_wdata,            32'd0);
        chk({tag, "_crst"}, {31'd0, cpu_rst},      32'd1);
        chk({tag, "_done"}, {31'd0, load_done},    32'd0);
        chk({tag, "_ferr"}, {31'd0, frame_err},    32'd0);
        chk({tag, "_oerr"}, {31'd0, overflow_err}, 32'd0);
    endtask

    task automatic do_reset();
        rx_serial = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic chk_write(input string name, input logic [AW-1:0] a, input logic [31:0] d);
        chk({name, "_cnt"}, 32'(wq_addr.size()), 32'd1);
        if (wq_addr.size() > 0) begin
            chk({name, "_addr"}, {28'd0, wq_addr.pop_front()}, {28'd0, a});
            chk({name, "_data"}, wq_data.pop_front(), d);
        end
    endtask

    task automatic apply_vec(input int i);
        send_byte(vecs[i].b0, 1'b1);
        send_byte(vecs[i].b1, 1'b1);
        send_byte(vecs[i].b2, 1'b1);
        send_byte(vecs[i].b3, 1'b1);
        tick(4);
        if (vecs[i].exp_we) begin
            chk_write($sformatf("vec%0d", i), vecs[i].exp_addr, vecs[i].exp_data);
        end else begin
            chk($sformatf("vec%0d_nowrite", i), 32'(wq_addr.size()), 32'd0);
        end
        chk($sformatf("vec%0d_ovf", i), {31'd0, overflow_err}, {31'd0, vecs[i].exp_ovf});
    endtask

    initial begin
        // Nominal image: two instructions.
        vecs[0] = '{8'h13, 8'h05, 8'hA0, 8'h00, 1'b1, 4'd0, 32'h00A0_0513, 1'b0};
        vecs[1] = '{8'h93, 8'h05, 8'h10, 8'h00, 1'b1, 4'd1, 32'h0010_0593, 1'b0};
        // Overflow image: 17 words into a 16-word memory.
        for (int i = 0; i < 17; i++) begin
            vecs[2+i].b0       = 8'(i);
            vecs[2+i].b1       = 8'hC3;
            vecs[2+i].b2       = 8'h5A;
            vecs[2+i].b3       = 8'(8'hF0 + i);
            vecs[2+i].exp_we   = (i < 16);
            vecs[2+i].exp_addr = AW'(i);
            vecs[2+i].exp_data = {8'(8'hF0 + i), 8'h5A, 8'hC3, 8'(i)};
            vecs[2+i].exp_ovf  = (i == 16);
        end

        // Reset state.
        tick(1);
        do_reset();
        check_reset("rst0");

        // Zero-length image.
        send_word(32'd0);
        tick(4);
        chk("zero_done",    {31'd0, load_done}, 32'd1);
        chk("zero_crst",    {31'd0, cpu_rst},   32'd0);
        chk("zero_nowrite", 32'(wq_addr.size()), 32'd0);

        // Start glitch, then nominal load.
        do_reset();
        rx_serial = 1'b0;
        tick(4);
        rx_serial = 1'b1;
        tick(40);
        chk("glitch_nowrite", 32'(wq_addr.size()), 32'd0);
        chk("glitch_ferr",    {31'd0, frame_err},  32'd0);
        chk("glitch_done",    {31'd0, load_done},  32'd0);
        send_word(32'd2);
        chk("hdr_crst", {31'd0, cpu_rst}, 32'd1);
        for (int i = 0; i < 2; i++) apply_vec(i);
        chk("nom_done",   {31'd0, load_done},  32'd1);
        chk("nom_crst",   {31'd0, cpu_rst},    32'd0);
        chk("nom_timing", 32'(done_cyc),       32'(last_we_cyc + 1));
        chk("nom_width",  32'(wide_cnt),       32'd0);
        chk("nom_ferr",   {31'd0, frame_err},  32'd0);
        // Bytes after the image are ignored.
        send_word(32'hFFFF_FFFF);
        chk("after_nowrite", 32'(wq_addr.size()), 32'd0);

        // Framing error: the bad byte is dropped from the stream.
        do_reset();
        send_word(32'd1);
        send_byte(8'h55, 1'b0);
        tick(4);
        chk("ferr_set", {31'd0, frame_err}, 32'd1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        tick(4);
        chk_write("ferr_wr", 4'd0, 32'h4433_2211);
        chk("ferr_done", {31'd0, load_done}, 32'd1);

        // Overflow.
        do_reset();
        send_word(32'h0000_0011);
        for (int i = 2; i < 19; i++) apply_vec(i);
        chk("ovf_done",  {31'd0, load_done}, 32'd1);
        chk("ovf_width", 32'(wide_cnt),      32'd0);

        // Reset during the second data word.
        do_reset();
        send_word(32'd2);
        send_word(32'h0BAD_F00D);
        tick(4);
        chk_write("mid_w0", 4'd0, 32'h0BAD_F00D);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        rst = 1'b1;
        tick(1);
        check_reset("rst_mid");
        rst = 1'b0;
        tick(2);
        wq_addr.delete();
        wq_data.delete();
        send_word(32'd2);
        send_word(32'hCAFE_F00D);
        tick(4);
        chk_write("fresh_w0", 4'd0, 32'hCAFE_F00D);
        chk("fresh_mid_done", {31'd0, load_done}, 32'd0);
        send_word(32'h1234_5678);
        tick(4);
        chk_write("fresh_w1", 4'd1, 32'h1234_5678);
        chk("fresh_done", {31'd0, load_done}, 32'd1);
        chk("fresh_crst", {31'd0, cpu_rst},   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Boot-time loader sitting between the board's rx_serial pin and the core's instruction memory write port.
- Receives a program over UART 8N1 and assembles little-endian 32-bit words.
- Writes each word to sequential instruction-memory addresses and holds the pipeline in reset until the whole image is loaded.
- Once released, the core starts fetching from PC 0 with the new image.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
- ADDR_WIDTH, 10, instruction memory word-address width; depth = 2**ADDR_WIDTH words.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- rx_serial  input  1  asynchronous UART line, idle high
- imem_we  output  1  one-cycle write strobe to instruction memory
- imem_addr  output  ADDR_WIDTH  word address for the write
- imem_wdata  output  32  assembled instruction word
- cpu_rst  output  1  reset to the pipeline; high while loading
- load_done  output  1  high once the image is fully written
- frame_err  output  1  sticky; a stop bit was sampled low
- overflow_err  output  1  sticky; image length exceeded memory depth

Behaviour:
- Reset values (every output):
  - imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, load_done=0, frame_err=0, overflow_err=0.
  - Both FSMs go to their initial states, all counters clear.
  - Reset mid-byte or mid-image aborts; loading restarts from the length header.
- Input sync:
  - rx_serial passes through a 2-flop synchronizer (reset value 1) before any use.
  - This adds 2 cycles of latency to all sampling points.
- RX FSM (IDLE, START, DATA, STOP, WAIT_IDLE):
  - IDLE: synced line low -> START, bit counter cleared.
  - START: after CLKS_PER_BIT/2 (integer division) cycles, sample the line. Low -> DATA. High -> IDLE (glitch, no byte, no error).
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles.
    - High: byte_valid pulses for 1 cycle, then IDLE.
    - Low: byte discarded, frame_err set, go to WAIT_IDLE.
  - WAIT_IDLE: stay until the line is sampled high, then IDLE.
- Loader FSM (L_LEN, L_DATA, L_DONE):
  - L_LEN: collect 4 bytes, little-endian, into word_count (32 bits).
    - On the 4th byte, word_count==0 -> L_DONE.
    - Otherwise -> L_DATA with word_idx=0 and byte_idx=0.
  - L_DATA:
    - Each byte shifts into byte lane byte_idx (byte 0 -> [7:0]).
    - On the 4th byte of a word, the next cycle drives:
      - imem_we=1 for exactly 1 cycle;
      - imem_addr = word_idx[ADDR_WIDTH-1:0];
      - imem_wdata = the assembled word.
    - Then word_idx increments.
    - If word_idx >= 2**ADDR_WIDTH, suppress the write (imem_we stays 0), set overflow_err, and still consume the word.
    - When word_idx reaches word_count after the final write cycle -> L_DONE.
  - L_DONE:
    - load_done=1 and cpu_rst=0, both registered: they change on the cycle after the final write strobe.
    - All further received bytes are ignored.
    - Only rst returns the loader to L_LEN.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- cpu_rst = 1 in every state except L_DONE.
- Frame errors do not advance byte_idx, so a corrupted byte is simply missing from the stream; the host must resend after reset.
- A byte completing on the same cycle as an imem_we pulse must be accepted; the byte path is never stalled.

Test Plan:
- Directed bench settings: CLKS_PER_BIT=16, ADDR_WIDTH=4.
- Nominal load:
  - Send 02 00 00 00, 13 05 A0 00, 93 05 10 00.
  - Expect write addr0=0x00A00513, then addr1=0x00100593, each imem_we exactly 1 cycle.
  - load_done=1 and cpu_rst=0 one cycle after the second strobe; no errors.
- Zero length:
  - Send 00 00 00 00.
  - Expect no imem_we; load_done=1 and cpu_rst=0 after the 4th stop bit.
- Framing error:
  - Header of 1 word, then a byte with stop bit forced 0, then 4 good bytes 11 22 33 44.
  - Expect frame_err=1 and a write of 0x44332211 to addr0.
- Start glitch:
  - Pulse rx low for 4 cycles, return high.
  - Expect no byte accepted and no error; a following valid load behaves as in the nominal case.
- Overflow:
  - Header 0x11 (17 words), send 17 words.
  - Expect writes at addr 0..15 only; overflow_err=1; load_done after the 17th word.
- Reset mid-load:
  - Assert rst for 1 cycle during the 2nd data word.
  - Expect all outputs at reset values and cpu_rst=1; a fresh full load then writes correctly starting at addr0.
